// File: rtl/lcd_bus_scheduler_pkg.sv
// ============================================================================
// Module  : lcd_pkg
// Brief   : Shared state encoding, HD44780 command bytes and init ROM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

    typedef logic [7:0] lcd_byte_t;

    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_INIT    = 3'd1;
    localparam logic [2:0] ST_SETUP   = 3'd2;
    localparam logic [2:0] ST_PULSE   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_WAIT    = 3'd5;
    localparam logic [2:0] ST_IDLE    = 3'd6;
    localparam logic [2:0] ST_LINEFIX = 3'd7;

    localparam lcd_byte_t FUNC_SET = 8'h38;
    localparam lcd_byte_t DISP_ON  = 8'h0C;
    localparam lcd_byte_t ENTRY    = 8'h06;
    localparam lcd_byte_t CLEAR    = 8'h01;
    localparam lcd_byte_t HOME     = 8'h02;
    localparam lcd_byte_t LINE0    = 8'h80;
    localparam lcd_byte_t LINE1    = 8'hC0;

    localparam int INIT_LEN = 5;

    function automatic lcd_byte_t init_rom(input logic [2:0] step);
        case (step)
            3'd0, 3'd1: init_rom = FUNC_SET;
            3'd2:       init_rom = DISP_ON;
            3'd3:       init_rom = ENTRY;
            default:    init_rom = CLEAR;
        endcase
    endfunction

    // A phase of N cycles loads N-1; a zero-length phase still takes one cycle.
    function automatic int phase_load(input int cycles);
        phase_load = (cycles < 1) ? 0 : cycles - 1;
    endfunction

    function automatic int imax(input int a, input int b);
        imax = (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_scheduler_if.sv
// ============================================================================
// Module  : lcd_bus_scheduler_if
// Brief   : Requester handshakes, status and LCD pin bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lcd_bus_scheduler_if;
    import lcd_pkg::*;

    logic      cmd_req;
    lcd_byte_t cmd_data;
    logic      cmd_ack;
    logic      chr_req;
    lcd_byte_t chr_data;
    logic      chr_ack;
    logic      init_done;
    logic      busy;
    logic      lcd_rs;
    logic      lcd_rw;
    logic      lcd_e;
    lcd_byte_t lcd_data;

    modport master (
        output cmd_req, cmd_data, chr_req, chr_data,
        input  cmd_ack, chr_ack, init_done, busy, lcd_rs, lcd_rw, lcd_e, lcd_data
    );

    modport slave (
        input  cmd_req, cmd_data, chr_req, chr_data,
        output cmd_ack, chr_ack, init_done, busy, lcd_rs, lcd_rw, lcd_e, lcd_data
    );

endinterface

`default_nettype wire

// File: rtl/lcd_bus_scheduler_phase_timer.sv
// ============================================================================
// Module  : lcd_phase_timer
// Brief   : Loadable down-counter; o_done while the count sits at zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_phase_timer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    output      logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_bus_scheduler.sv
// ============================================================================
// Module  : lcd_bus_scheduler
// Brief   : HD44780 bus owner: power-on init, cmd/chr arbitration, cursor wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES = 750000,
    parameter int SETUP_CYCLES   = 3,
    parameter int E_CYCLES       = 12,
    parameter int HOLD_CYCLES    = 2,
    parameter int EXEC_CYCLES    = 2500,
    parameter int CLEAR_CYCLES   = 82000,
    parameter int LINE_LEN       = 16
) (
    input wire logic          clk,
    input wire logic          reset_n,
    lcd_bus_scheduler_if.slave bus
);

    localparam int c_MAX_CYC = imax(imax(imax(POWERUP_CYCLES, SETUP_CYCLES), imax(E_CYCLES, HOLD_CYCLES)),
                                    imax(EXEC_CYCLES, CLEAR_CYCLES));
    localparam int c_TW    = (c_MAX_CYC < 2) ? 1 : $clog2(c_MAX_CYC);
    localparam int c_COL_W = (LINE_LEN < 2) ? 1 : $clog2(LINE_LEN);

    localparam logic [c_TW-1:0] c_LD_POWERUP = c_TW'(phase_load(POWERUP_CYCLES));
    localparam logic [c_TW-1:0] c_LD_SETUP   = c_TW'(phase_load(SETUP_CYCLES));
    localparam logic [c_TW-1:0] c_LD_E       = c_TW'(phase_load(E_CYCLES));
    localparam logic [c_TW-1:0] c_LD_HOLD    = c_TW'(phase_load(HOLD_CYCLES));
    localparam logic [c_TW-1:0] c_LD_EXEC    = c_TW'(phase_load(EXEC_CYCLES));
    localparam logic [c_TW-1:0] c_LD_CLEAR   = c_TW'(phase_load(CLEAR_CYCLES));
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(LINE_LEN - 1);

    logic [2:0]         r_state;
    logic [2:0]         r_step;
    logic [c_COL_W-1:0] r_col;
    logic               r_line;
    logic               r_fix;
    logic               r_rs;
    lcd_byte_t          r_data;
    logic               r_cmd_ack;
    logic               r_chr_ack;
    logic               r_init_done;

    logic               w_done;
    logic               w_load;
    logic [c_TW-1:0]    w_load_val;
    logic               w_is_clear;
    logic               w_grant_cmd;
    logic               w_grant_chr;

    lcd_phase_timer #(
        .WIDTH     (c_TW),
        .RESET_VAL (c_LD_POWERUP)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    assign w_is_clear  = !r_rs && ((r_data == CLEAR) || (r_data == HOME));
    assign w_grant_cmd = (r_state == ST_IDLE) && r_init_done && bus.cmd_req;
    assign w_grant_chr = (r_state == ST_IDLE) && r_init_done && !bus.cmd_req && bus.chr_req;

    // The timer is loaded on the last cycle of the preceding state so each phase is exact.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_INIT, ST_LINEFIX: begin
                w_load     = 1'b1;
                w_load_val = c_LD_SETUP;
            end
            ST_IDLE: begin
                w_load     = w_grant_cmd || w_grant_chr;
                w_load_val = c_LD_SETUP;
            end
            ST_SETUP: begin
                w_load     = w_done;
                w_load_val = c_LD_E;
            end
            ST_PULSE: begin
                w_load     = w_done;
                w_load_val = c_LD_HOLD;
            end
            ST_HOLD: begin
                w_load     = w_done;
                w_load_val = w_is_clear ? c_LD_CLEAR : c_LD_EXEC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_POWERUP;
            r_step      <= 3'd0;
            r_col       <= '0;
            r_line      <= 1'b0;
            r_fix       <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_cmd_ack   <= 1'b0;
            r_chr_ack   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            r_cmd_ack <= 1'b0;
            r_chr_ack <= 1'b0;
            case (r_state)
                ST_POWERUP: if (w_done) r_state <= ST_INIT;
                ST_INIT: begin
                    r_rs    <= 1'b0;
                    r_data  <= init_rom(r_step);
                    r_fix   <= 1'b0;
                    r_state <= ST_SETUP;
                end
                ST_IDLE: begin
                    if (w_grant_cmd) begin
                        r_cmd_ack <= 1'b1;
                        r_rs      <= 1'b0;
                        r_data    <= bus.cmd_data;
                        r_state   <= ST_SETUP;
                        if ((bus.cmd_data == CLEAR) || (bus.cmd_data == HOME)) begin
                            r_col  <= '0;
                            r_line <= 1'b0;
                        end else if (bus.cmd_data[7]) begin
                            r_line <= bus.cmd_data[6];
                            if (int'(bus.cmd_data[3:0]) > LINE_LEN - 1)
                                r_col <= c_LAST_COL;
                            else
                                r_col <= c_COL_W'(bus.cmd_data[3:0]);
                        end
                    end else if (w_grant_chr) begin
                        r_chr_ack <= 1'b1;
                        r_rs      <= 1'b1;
                        r_data    <= bus.chr_data;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: if (w_done) r_state <= ST_PULSE;
                ST_PULSE: if (w_done) r_state <= ST_HOLD;
                ST_HOLD:  if (w_done) r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_done) begin
                        if (!r_init_done) begin
                            if (r_step == 3'(INIT_LEN - 1)) begin
                                r_init_done <= 1'b1;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_step  <= r_step + 3'd1;
                                r_state <= ST_INIT;
                            end
                        end else if (r_fix) begin
                            r_fix   <= 1'b0;
                            r_col   <= '0;
                            r_line  <= ~r_line;
                            r_state <= ST_IDLE;
                        end else if (r_rs && (r_col == c_LAST_COL)) begin
                            r_state <= ST_LINEFIX;
                        end else begin
                            if (r_rs) r_col <= r_col + c_COL_W'(1);
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_LINEFIX: begin
                    r_rs    <= 1'b0;
                    r_data  <= r_line ? LINE0 : LINE1;
                    r_fix   <= 1'b1;
                    r_state <= ST_SETUP;
                end
                default: r_state <= ST_POWERUP;
            endcase
        end
    end

    assign bus.cmd_ack   = r_cmd_ack;
    assign bus.chr_ack   = r_chr_ack;
    assign bus.init_done = r_init_done;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.lcd_rs    = r_rs;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_e     = (r_state == ST_PULSE);
    assign bus.lcd_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_scheduler.sv
// ============================================================================
// Module  : tb_lcd_bus_scheduler
// Brief   : Directed bench for lcd_bus_scheduler with shortened timing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_bus_scheduler;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    lcd_bus_scheduler_if bus ();

    lcd_bus_scheduler #(
        .POWERUP_CYCLES (20),
        .SETUP_CYCLES   (2),
        .E_CYCLES       (3),
        .HOLD_CYCLES    (1),
        .EXEC_CYCLES    (5),
        .CLEAR_CYCLES   (10),
        .LINE_LEN       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge
    logic [8:0] q_pulse[$];
    int         q_width[$];
    int         q_gap[$];
    int         cyc = 0, last_fall = 0, done_rise = 0, cur_w = 0;
    int         n_cmd_ack = 0, n_chr_ack = 0, n_rw_bad = 0;
    logic       prev_e = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.lcd_rw !== 1'b0) n_rw_bad++;
        if (bus.cmd_ack) n_cmd_ack++;
        if (bus.chr_ack) n_chr_ack++;
        if (bus.init_done && !prev_done) done_rise = cyc;
        if (bus.lcd_e && !prev_e) begin
            q_pulse.push_back({bus.lcd_rs, bus.lcd_data});
            q_gap.push_back(cyc - last_fall);
            cur_w = 1;
        end else if (bus.lcd_e) begin
            cur_w++;
        end else if (prev_e) begin
            q_width.push_back(cur_w);
            last_fall = cyc;
        end
        prev_e    = bus.lcd_e;
        prev_done = bus.init_done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_pulse.delete();
        q_width.delete();
        q_gap.delete();
        n_cmd_ack = 0;
        n_chr_ack = 0;
    endtask

    task automatic check_pulse(input string tag, input int idx, input logic [8:0] exp);
        logic [31:0] g;
        g = 32'hDEAD;
        if (idx < q_pulse.size()) g = 32'(q_pulse[idx]);
        check_eq(tag, g, 32'(exp));
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!bus.init_done && n < 1000) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.init_done), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        check_eq("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic send_chr(input logic [7:0] d, output int lat);
        bus.chr_data = d;
        bus.chr_req  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.chr_ack && lat < 300);
        check_eq("chr_ack_seen", 32'(bus.chr_ack), 32'd1);
        bus.chr_req = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] d);
        int n;
        bus.cmd_data = d;
        bus.cmd_req  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cmd_ack && n < 300);
        check_eq("cmd_ack_seen", 32'(bus.cmd_ack), 32'd1);
        bus.cmd_req = 1'b0;
    endtask

    logic [8:0] init_seq [5] = '{9'h038, 9'h038, 9'h00C, 9'h006, 9'h001};
    logic [8:0] wrap_seq [10] = '{9'h141, 9'h142, 9'h143, 9'h144, 9'h0C0,
                                  9'h145, 9'h146, 9'h147, 9'h148, 9'h080};

    initial begin
        int lat, cnt, n;
        reset_n      = 1'b0;
        bus.cmd_req  = 1'b0;
        bus.cmd_data = 8'h00;
        bus.chr_req  = 1'b0;
        bus.chr_data = 8'h00;
        repeat (3) tick();

        // Reset state: {e, rs, rw, cmd_ack, chr_ack, init_done, busy}
        check_eq("rst_ctrl", 32'({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.cmd_ack,
                                  bus.chr_ack, bus.init_done, bus.busy}), 32'b0000001);
        check_eq("rst_data", 32'(bus.lcd_data), 32'h00);

        // 1: power-on init sequence
        clear_mon();
        reset_n = 1'b1;
        wait_init("t1_init_done");
        check_eq("t1_npulse", 32'(q_pulse.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_pulse($sformatf("t1_pulse%0d", i), i, init_seq[i]);
            check_eq($sformatf("t1_width%0d", i), (i < q_width.size()) ? 32'(q_width[i]) : 32'hDEAD, 32'd3);
        end
        check_eq("t1_clear_gap", 32'(done_rise - last_fall), 32'd11);
        check_eq("t1_busy_low", 32'(bus.busy), 32'd0);

        // 2: single character
        clear_mon();
        send_chr(8'h41, lat);
        check_eq("t2_ack_latency", 32'(lat), 32'd1);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            tick();
        end
        check_eq("t2_busy_cycles", 32'(cnt), 32'd11);
        check_eq("t2_npulse", 32'(q_pulse.size()), 32'd1);
        check_pulse("t2_pulse", 0, 9'h141);
        check_eq("t2_nack", 32'(n_chr_ack), 32'd1);

        // 3: simultaneous cmd and chr requests
        clear_mon();
        bus.cmd_data = 8'h01;
        bus.chr_data = 8'h42;
        bus.cmd_req  = 1'b1;
        bus.chr_req  = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cmd_ack && !bus.chr_ack && n < 100);
        check_eq("t3_first_ack", 32'({bus.cmd_ack, bus.chr_ack}), 32'b10);
        bus.cmd_req = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.chr_ack && n < 200);
        check_eq("t3_chr_ack", 32'(bus.chr_ack), 32'd1);
        bus.chr_req = 1'b0;
        wait_idle();
        check_pulse("t3_pulse0", 0, 9'h001);
        check_pulse("t3_pulse1", 1, 9'h142);
        check_eq("t3_clear_gap", (q_gap.size() > 1) ? 32'(q_gap[1]) : 32'hDEAD, 32'd14);
        check_eq("t3_acks", 32'({n_cmd_ack[7:0], n_chr_ack[7:0]}), 32'h0101);

        // 4: end-of-line fix-up and wrap
        send_cmd(8'h02);
        wait_idle();
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            send_chr(8'h41 + 8'(i), lat);
            wait_idle();
        end
        check_eq("t4_npulse", 32'(q_pulse.size()), 32'd10);
        for (int i = 0; i < 10; i++) check_pulse($sformatf("t4_pulse%0d", i), i, wrap_seq[i]);
        check_eq("t4_nack", 32'(n_chr_ack), 32'd8);

        // 5: reset during a character pulse
        send_chr(8'h55, lat);
        n = 0;
        while (!bus.lcd_e && n < 50) begin
            tick();
            n++;
        end
        check_eq("t5_in_pulse", 32'(bus.lcd_e), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t5_async", 32'({bus.lcd_e, bus.init_done, bus.busy}), 32'b001);
        repeat (2) tick();
        clear_mon();
        reset_n = 1'b1;
        wait_init("t5_init_done");
        check_eq("t5_npulse", 32'(q_pulse.size()), 32'd5);
        for (int i = 0; i < 5; i++) check_pulse($sformatf("t5_pulse%0d", i), i, init_seq[i]);
        check_eq("t5_no_ack", 32'(n_cmd_ack + n_chr_ack), 32'd0);

        // 6: command held through power-up
        reset_n = 1'b0;
        tick();
        bus.cmd_data = 8'h0C;
        bus.cmd_req  = 1'b1;
        clear_mon();
        tick();
        reset_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cmd_ack && n < 1000);
        check_eq("t6_ack", 32'(bus.cmd_ack), 32'd1);
        check_eq("t6_after_init", 32'(bus.init_done), 32'd1);
        bus.cmd_req = 1'b0;
        wait_idle();
        repeat (3) tick();
        check_eq("t6_nack", 32'(n_cmd_ack), 32'd1);
        check_eq("t6_npulse", 32'(q_pulse.size()), 32'd6);
        check_pulse("t6_pulse", 5, 9'h00C);

        check_eq("rw_low", 32'(n_rw_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
